// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared funct3 encodings and slot metadata for the branch resolver
//
// Purpose: conditional-branch funct3 encodings and the decode-metadata struct
//          carried by the EX slot of branch_resolver.
// Ports:   none (package).

package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Decode fields latched alongside the ID slot contents when moving to EX.
    typedef struct packed {
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [2:0] funct3;
    } br_meta_t;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - conditional-branch comparator selected by funct3
//
// Purpose: evaluates the branch condition for a conditional branch.
// Ports:
//   funct3 - branch comparison encoding
//   rs1    - first forwarded operand
//   rs2    - second forwarded operand
//   cond   - 1 when the condition holds; 0 for unused encodings 010/011

module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cond = (rs1 <  rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - two-slot branch resolution with predictor update and statistics
//
// Purpose: carries fetched instructions through ID and EX slots, resolves
//          branch/jal/jalr direction and target in EX, flags mispredictions
//          and keeps saturating branch/mispredict counters.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   stall                             - freeze slots and counters
//   flush_in                          - kill ID and EX slots on this edge
//   if_valid/pc/pred_taken/pred_target - IF capture
//   id_is_branch/jal/jalr/funct3/imm   - ID decode, used while ID slot valid
//   ex_rs1, ex_rs2                    - forwarded operands for the EX slot
//   ex_is_branch/pc/taken/prev_taken/target - predictor update
//   ex_mispredict                     - resolved outcome differs from prediction
//   branch_cnt, mispredict_cnt        - saturating statistics

module branch_resolver
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush_in,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_pred_taken,
    input  logic [XLEN-1:0]  if_pred_target,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic             id_is_jalr,
    input  logic [2:0]       id_funct3,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    output logic             ex_is_branch,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_taken,
    output logic             ex_prev_taken,
    output logic [XLEN-1:0]  ex_target,
    output logic             ex_mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    // ID slot
    logic            id_valid_q,       id_valid_d;
    logic [XLEN-1:0] id_pc_q,          id_pc_d;
    logic            id_pred_taken_q,  id_pred_taken_d;
    logic [XLEN-1:0] id_pred_target_q, id_pred_target_d;

    // EX slot
    logic            ex_valid_q,       ex_valid_d;
    logic [XLEN-1:0] ex_pc_q,          ex_pc_d;
    logic            ex_pred_taken_q,  ex_pred_taken_d;
    logic [XLEN-1:0] ex_pred_target_q, ex_pred_target_d;
    br_meta_t        ex_meta_q,        ex_meta_d;
    logic [XLEN-1:0] ex_imm_q,         ex_imm_d;

    logic [CNT_W-1:0] branch_cnt_q,     branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic            cond;
    logic            is_ctrl;
    logic [XLEN-1:0] pc_imm_sum;
    logic [XLEN-1:0] jalr_sum;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (ex_meta_q.funct3),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .cond   (cond)
    );

    // ------------------------------------------------------------------
    // Resolution, purely combinational from the EX slot and operands
    // ------------------------------------------------------------------
    assign is_ctrl    = ex_meta_q.is_branch | ex_meta_q.is_jal | ex_meta_q.is_jalr;
    assign pc_imm_sum = ex_pc_q + ex_imm_q;
    assign jalr_sum   = (ex_rs1 + ex_imm_q) & ~XLEN'(1);

    always_comb begin
        ex_is_branch  = ex_valid_q & is_ctrl;
        ex_pc         = ex_valid_q ? ex_pc_q : '0;
        ex_prev_taken = ex_valid_q & ex_pred_taken_q;
        ex_taken      = 1'b0;
        ex_target     = '0;
        if (ex_is_branch) begin
            ex_taken = ex_meta_q.is_jal | ex_meta_q.is_jalr | cond;
        end
        if (ex_valid_q) begin
            if (ex_meta_q.is_jalr) begin
                ex_target = jalr_sum;
            end else if (ex_taken) begin
                ex_target = pc_imm_sum;
            end else begin
                ex_target = ex_pc_q + XLEN'(4);
            end
        end
        ex_mispredict = ex_is_branch &
                        ((ex_taken != ex_pred_taken_q) |
                         (ex_taken & ex_pred_taken_q & (ex_target != ex_pred_target_q)));
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    // ------------------------------------------------------------------
    // Slot and counter next state
    // ------------------------------------------------------------------
    always_comb begin
        id_valid_d       = id_valid_q;
        id_pc_d          = id_pc_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        ex_valid_d       = ex_valid_q;
        ex_pc_d          = ex_pc_q;
        ex_pred_taken_d  = ex_pred_taken_q;
        ex_pred_target_d = ex_pred_target_q;
        ex_meta_d        = ex_meta_q;
        ex_imm_d         = ex_imm_q;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        if (!stall) begin
            id_valid_d       = if_valid & ~flush_in;
            id_pc_d          = if_pc;
            id_pred_taken_d  = if_pred_taken;
            id_pred_target_d = if_pred_target;

            ex_valid_d       = id_valid_q & ~flush_in;
            ex_pc_d          = id_pc_q;
            ex_pred_taken_d  = id_pred_taken_q;
            ex_pred_target_d = id_pred_target_q;
            // Decode inputs are meaningless when the ID slot is empty.
            if (id_valid_q) begin
                ex_meta_d = '{is_branch: id_is_branch, is_jal: id_is_jal,
                              is_jalr: id_is_jalr, funct3: id_funct3};
                ex_imm_d  = id_imm;
            end else begin
                ex_meta_d = '0;
                ex_imm_d  = '0;
            end

            // The EX instruction resolves on this edge even when flush
            // kills the slots behind it.
            if (ex_is_branch && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (ex_mispredict && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q       <= 1'b0;
            id_pc_q          <= '0;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= '0;
            ex_pred_taken_q  <= 1'b0;
            ex_pred_target_q <= '0;
            ex_meta_q        <= '0;
            ex_imm_q         <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            id_valid_q       <= id_valid_d;
            id_pc_q          <= id_pc_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
            ex_valid_q       <= ex_valid_d;
            ex_pc_q          <= ex_pc_d;
            ex_pred_taken_q  <= ex_pred_taken_d;
            ex_pred_target_q <= ex_pred_target_d;
            ex_meta_q        <= ex_meta_d;
            ex_imm_q         <= ex_imm_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver

module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst, stall, flush_in;
    logic        if_valid, if_pred_taken;
    logic [31:0] if_pc, if_pred_target;
    logic        id_is_branch, id_is_jal, id_is_jalr;
    logic [2:0]  id_funct3;
    logic [31:0] id_imm, ex_rs1, ex_rs2;

    logic        ex_is_branch, ex_taken, ex_prev_taken, ex_mispredict;
    logic [31:0] ex_pc, ex_target, branch_cnt, mispredict_cnt;

    logic        s_is_branch, s_taken, s_prev_taken, s_mispredict;
    logic [31:0] s_pc, s_target;
    logic [1:0]  s_branch_cnt, s_mispredict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_in(flush_in),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target),
        .id_is_branch(id_is_branch), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
        .id_funct3(id_funct3), .id_imm(id_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_prev_taken(ex_prev_taken), .ex_target(ex_target),
        .ex_mispredict(ex_mispredict),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    // Narrow-counter copy fed the same stream: saturation is reached quickly.
    branch_resolver #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush_in(flush_in),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target),
        .id_is_branch(id_is_branch), .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr),
        .id_funct3(id_funct3), .id_imm(id_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_is_branch(s_is_branch), .ex_pc(s_pc), .ex_taken(s_taken),
        .ex_prev_taken(s_prev_taken), .ex_target(s_target),
        .ex_mispredict(s_mispredict),
        .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction from IF into EX; returns with it in EX and operands applied.
    task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                         input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
        step();
        if_valid = 1'b0;
        id_is_branch = br; id_is_jal = jal; id_is_jalr = jalr; id_funct3 = f3; id_imm = imm;
        step();
        ex_rs1 = rs1; ex_rs2 = rs2;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush_in = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0;
        id_is_branch = 1'b0; id_is_jal = 1'b0; id_is_jalr = 1'b0; id_funct3 = '0; id_imm = '0;
        ex_rs1 = 32'h1234; ex_rs2 = 32'h1234;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (ex_is_branch !== 1'b0) begin errors++; $display("FAIL reset_is_branch got=%b exp=0", ex_is_branch); end
        checks++; if (ex_taken !== 1'b0 || ex_prev_taken !== 1'b0 || ex_mispredict !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b%b exp=000", ex_taken, ex_prev_taken, ex_mispredict); end
        checks++; if (ex_pc !== 32'h0 || ex_target !== 32'h0) begin errors++; $display("FAIL reset_pc_target got=%h/%h exp=0/0", ex_pc, ex_target); end
        checks++; if (branch_cnt !== 32'h0 || mispredict_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); end
    endtask

    task automatic test_beq();
        issue(32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'd5, 32'd5);
        checks++; if (ex_is_branch !== 1'b1 || ex_pc !== 32'h40) begin errors++; $display("FAIL beq_is_branch_pc got=%b/%h exp=1/40", ex_is_branch, ex_pc); end
        checks++; if (ex_taken !== 1'b1 || ex_target !== 32'h60) begin errors++; $display("FAIL beq_taken_target got=%b/%h exp=1/60", ex_taken, ex_target); end
        checks++; if (ex_mispredict !== 1'b1 || ex_prev_taken !== 1'b0) begin errors++; $display("FAIL beq_mispredict got=%b/%b exp=1/0", ex_mispredict, ex_prev_taken); end
        step();
        checks++; if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd1) begin errors++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", branch_cnt, mispredict_cnt); end
        checks++; if (ex_is_branch !== 1'b0) begin errors++; $display("FAIL beq_bubble got=%b exp=0", ex_is_branch); end
    endtask

    task automatic test_signed_unsigned();
        issue(32'h70, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'd1);
        checks++; if (ex_taken !== 1'b1 || ex_target !== 32'h80 || ex_mispredict !== 1'b0) begin errors++; $display("FAIL blt got=%b/%h/%b exp=1/80/0", ex_taken, ex_target, ex_mispredict); end
        step();
        issue(32'h70, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 3'b110, 32'h10, 32'hFFFF_FFFF, 32'd1);
        checks++; if (ex_taken !== 1'b0 || ex_target !== 32'h74 || ex_mispredict !== 1'b1) begin errors++; $display("FAIL bltu got=%b/%h/%b exp=0/74/1", ex_taken, ex_target, ex_mispredict); end
        step();
        checks++; if (branch_cnt !== 32'd3 || mispredict_cnt !== 32'd2) begin errors++; $display("FAIL blt_cnt got=%0d/%0d exp=3/2", branch_cnt, mispredict_cnt); end
        // Reserved funct3 010: never taken even with equal operands.
        issue(32'h90, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'd7, 32'd7);
        checks++; if (ex_taken !== 1'b0 || ex_target !== 32'h94 || ex_mispredict !== 1'b0) begin errors++; $display("FAIL f3_010 got=%b/%h/%b exp=0/94/0", ex_taken, ex_target, ex_mispredict); end
        step();
        checks++; if (s_branch_cnt !== 2'd3 || s_mispredict_cnt !== 2'd2) begin errors++; $display("FAIL sat_branch got=%0d/%0d exp=3/2", s_branch_cnt, s_mispredict_cnt); end
    endtask

    task automatic test_jumps();
        issue(32'h200, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 3'b000, 32'h4, 32'h103, 32'h0);
        checks++; if (ex_taken !== 1'b1 || ex_target !== 32'h106 || ex_mispredict !== 1'b1) begin errors++; $display("FAIL jalr got=%b/%h/%b exp=1/106/1", ex_taken, ex_target, ex_mispredict); end
        step();
        issue(32'h300, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0);
        checks++; if (ex_taken !== 1'b1 || ex_target !== 32'h400 || ex_mispredict !== 1'b0) begin errors++; $display("FAIL jal got=%b/%h/%b exp=1/400/0", ex_taken, ex_target, ex_mispredict); end
        step();
        checks++; if (branch_cnt !== 32'd6 || mispredict_cnt !== 32'd3) begin errors++; $display("FAIL jump_cnt got=%0d/%0d exp=6/3", branch_cnt, mispredict_cnt); end
        checks++; if (s_branch_cnt !== 2'd3 || s_mispredict_cnt !== 2'd3) begin errors++; $display("FAIL sat_both got=%0d/%0d exp=3/3", s_branch_cnt, s_mispredict_cnt); end
    endtask

    task automatic test_stall();
        issue(32'h40, 1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'd9, 32'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ex_is_branch !== 1'b1 || ex_taken !== 1'b1 || ex_target !== 32'h60 || ex_mispredict !== 1'b0) begin errors++; $display("FAIL stall_outputs cyc=%0d got=%b/%b/%h/%b exp=1/1/60/0", i, ex_is_branch, ex_taken, ex_target, ex_mispredict); end
            checks++; if (branch_cnt !== 32'd6 || mispredict_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt cyc=%0d got=%0d/%0d exp=6/3", i, branch_cnt, mispredict_cnt); end
        end
        stall = 1'b0;
        step();
        checks++; if (branch_cnt !== 32'd7 || mispredict_cnt !== 32'd3) begin errors++; $display("FAIL stall_release_cnt got=%0d/%0d exp=7/3", branch_cnt, mispredict_cnt); end
        step();
        checks++; if (branch_cnt !== 32'd7) begin errors++; $display("FAIL stall_once got=%0d exp=7", branch_cnt); end
    endtask

    task automatic test_flush();
        // A: beq pc 0x500, predicted not taken, resolves taken -> mispredict
        if_valid = 1'b1; if_pc = 32'h500; if_pred_taken = 1'b0; if_pred_target = 32'h0;
        step();
        // B enters ID while A decodes
        if_pc = 32'h504; if_pred_taken = 1'b0;
        id_is_branch = 1'b1; id_is_jal = 1'b0; id_is_jalr = 1'b0; id_funct3 = 3'b000; id_imm = 32'h8;
        step();
        if_valid = 1'b0;
        ex_rs1 = 32'd1; ex_rs2 = 32'd1;
        flush_in = 1'b1;
        #1;
        checks++; if (ex_is_branch !== 1'b1 || ex_mispredict !== 1'b1) begin errors++; $display("FAIL flush_pre got=%b/%b exp=1/1", ex_is_branch, ex_mispredict); end
        step();
        flush_in = 1'b0;
        #1;
        checks++; if (ex_is_branch !== 1'b0) begin errors++; $display("FAIL flush_killed got=%b exp=0", ex_is_branch); end
        checks++; if (branch_cnt !== 32'd8 || mispredict_cnt !== 32'd4) begin errors++; $display("FAIL flush_cnt got=%0d/%0d exp=8/4", branch_cnt, mispredict_cnt); end
        step();
        checks++; if (ex_is_branch !== 1'b0 || branch_cnt !== 32'd8 || mispredict_cnt !== 32'd4) begin errors++; $display("FAIL flush_after got=%b/%0d/%0d exp=0/8/4", ex_is_branch, branch_cnt, mispredict_cnt); end
        checks++; if (s_branch_cnt !== 2'd3 || s_mispredict_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d/%0d exp=3/3", s_branch_cnt, s_mispredict_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        issue(32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h10, 32'd1, 32'd2);
        stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (ex_is_branch !== 1'b0 || ex_pc !== 32'h0 || ex_target !== 32'h0) begin errors++; $display("FAIL rst_stall_out got=%b/%h/%h exp=0/0/0", ex_is_branch, ex_pc, ex_target); end
        checks++; if (branch_cnt !== 32'h0 || mispredict_cnt !== 32'h0 || s_branch_cnt !== 2'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d/%0d/%0d exp=0/0/0", branch_cnt, mispredict_cnt, s_branch_cnt); end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jumps();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/data width.
REQ-002 SHALL have parameter CNT_W, default 32: statistics counter width.
REQ-003 SHALL have ports clk in 1 (sole clock) and rst in 1 (one clock; reset synchronous, active-high).
REQ-004 SHALL have ports stall in 1 (memory stall, freezes block) and flush_in in 1 (predictor redirect, kills younger slots).
REQ-005 SHALL have IF-capture ports if_valid in 1, if_pc in XLEN, if_pred_taken in 1 and if_pred_target in XLEN.
REQ-006 SHALL have ID-decode ports id_is_branch in 1, id_is_jal in 1, id_is_jalr in 1, id_funct3 in 3 and id_imm in XLEN (sign-extended).
REQ-007 SHALL have EX-operand ports ex_rs1 in XLEN and ex_rs2 in XLEN (forwarded values).
REQ-008 SHALL have predictor-update outputs ex_is_branch 1, ex_pc XLEN, ex_taken 1, ex_prev_taken 1 and ex_target XLEN.
REQ-009 SHALL have outputs ex_mispredict 1, branch_cnt CNT_W and mispredict_cnt CNT_W.

Function
REQ-010 SHALL hold two register slots, ID (valid, pc, pred_taken, pred_target) and EX (ID slot plus decode fields), loading IF->ID and ID->EX on each non-stalled edge.
REQ-011 SHALL hold both slots and both counters unchanged on any edge where stall=1.
REQ-012 SHALL clear the ID and EX valid bits on the edge where flush_in=1 and stall=0; stall takes precedence over flush.
REQ-013 SHALL drive all outputs combinationally from the EX slot and ex_rs1/ex_rs2: an instruction captured at IF in cycle n appears at outputs in cycle n+2 if unstalled.
REQ-014 SHALL assert ex_is_branch = EX.valid & (is_branch | is_jal | is_jalr), and ex_prev_taken = EX.pred_taken.
REQ-015 SHALL compute conditional taken per funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 SHALL be not taken.
REQ-016 SHALL force ex_taken=1 for jal and jalr, and ex_taken=0 whenever ex_is_branch=0.
REQ-017 SHALL set ex_target to pc+imm (branch/jal taken), (rs1+imm) with bit0 cleared (jalr), or pc+4 (conditional not taken); all sums SHALL be mod 2^XLEN.
REQ-018 SHALL assert ex_mispredict = ex_is_branch & ((ex_taken != pred_taken) | (ex_taken & pred_taken & ex_target != pred_target)).
REQ-019 SHALL increment branch_cnt on non-stalled edges with ex_is_branch=1, and mispredict_cnt on those with ex_mispredict=1.
REQ-020 SHALL saturate both counters at all-ones, with no wrap.
REQ-021 SHALL ignore ID-decode inputs while the ID slot is invalid, loading the EX slot with valid=0.

Reset
REQ-022 SHALL clear both slot valid bits and both counters on any rst=1 edge, including mid-stall or mid-flush; rst SHALL override stall and flush_in.
REQ-023 SHALL, while EX is invalid after reset, drive ex_is_branch, ex_taken, ex_prev_taken and ex_mispredict to 0 and ex_pc/ex_target to 0.

Structure
REQ-024 SHALL take funct3 encodings (BEQ..BGEU) and the slot-metadata struct from shared package branch_pkg.
REQ-025 SHALL implement the comparator (REQ-015) as sub-module branch_cmp (inputs funct3, rs1, rs2; output cond).

Verification
REQ-026 SHALL cover: beq at pc 0x40, imm 0x20, rs1=rs2=5, predicted not taken -> cycle n+2: taken=1, target=0x60, mispredict=1, both counters=1.
REQ-027 SHALL cover: blt with rs1=0xFFFFFFFF, rs2=1, predicted taken to 0x80 at pc 0x70 with imm 0x10 -> taken=1, mispredict=0; the same operands with bltu -> taken=0, target=0x74, mispredict=1.
REQ-028 SHALL cover: jalr with rs1=0x103, imm 4 -> target=0x106 (bit0 cleared); a predicted target of 0x104 -> mispredict=1.
REQ-029 SHALL cover: a branch in EX with stall held 3 cycles -> outputs stable, counters increment exactly once after stall drops.
REQ-030 SHALL cover: flush_in=1 with stall=0 while ID and EX hold branches -> next cycle ex_is_branch=0 and the counters do not advance for the killed slots.
REQ-031 SHALL cover: counters preloaded to all-ones via forced state, plus one more mispredicted branch -> both remain all-ones; rst asserted mid-stall -> everything zero the next cycle.
